// File: rtl/equiv_pkg.sv
// Shared definitions for the equivalence sweep checker.
// Holds the sweep FSM state encoding and the vector-count helper.
package equiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/equiv_sweep_checker_settle_timer.sv
// settle_timer: loadable down-counter; expire_o is high in the CYCLES-th enabled cycle after load.
// Latency: CYCLES enabled cycles from load to expire. No backpressure; counts whenever en_i is high.
module settle_timer #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int          W      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int unsigned RELOAD = CYCLES - 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD[W-1:0];
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with CYCLES-1, so the zero count is reached in the last hold cycle.
  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/equiv_sweep_checker.sv
// Drives every input vector onto two netlists, compares masked outputs, reports pass/fail summary.
// Latency: each vector takes SETTLE_CYC+1 cycles; done pulses 2^N_IN*(SETTLE_CYC+1)+1 cycles after start.
// No backpressure: start is only honoured in IDLE; all outputs are registered.
module equiv_sweep_checker
  import equiv_pkg::*;
#(
  parameter int N_IN         = 2,
  parameter int N_OUT        = 2,
  parameter int SETTLE_CYC   = 2,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] out_mask,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp_a,
  input  logic [N_OUT-1:0] resp_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic [N_IN:0]    fail_count
);

  localparam int          NV       = vec_count(N_IN);
  localparam int unsigned NV_U     = NV;
  localparam int unsigned LAST_U   = NV - 1;
  localparam logic [N_IN:0] LAST_VEC = LAST_U[N_IN:0];
  localparam logic [N_IN:0] MAX_FAIL = NV_U[N_IN:0];

  state_e           state_q, state_d;
  logic [N_IN:0]    vec_q, vec_d;
  logic [N_OUT-1:0] mask_q, mask_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic [N_IN:0]    fcnt_q, fcnt_d;

  logic tmr_load, tmr_en, tmr_expire;
  logic mismatch, end_sweep;

  settle_timer #(
    .CYCLES(SETTLE_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    mask_d    = mask_q;
    stim_d    = stim_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    ffv_d     = ffv_q;
    fcnt_d    = fcnt_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    mismatch  = |((resp_a ^ resp_b) & mask_q);
    end_sweep = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stim_d = '0;
        busy_d = 1'b0;
        if (start) begin
          mask_d   = out_mask;
          fcnt_d   = '0;
          ffv_d    = '0;
          pass_d   = 1'b0;
          vec_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          state_d = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        if (mismatch) begin
          if (fcnt_q == '0) begin
            ffv_d = vec_q[N_IN-1:0];
          end
          if (fcnt_q != MAX_FAIL) begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        // The extra counter bit keeps the last-vector test independent of wrap-around.
        end_sweep = (vec_q == LAST_VEC) || ((STOP_ON_FAIL != 0) && mismatch);
        if (end_sweep) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          stim_d  = '0;
          pass_d  = (fcnt_d == '0);
        end else begin
          vec_d    = vec_q + 1'b1;
          stim_d   = vec_d[N_IN-1:0];
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      mask_q  <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ffv_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign first_fail_vec = ffv_q;
  assign fail_count     = fcnt_q;

endmodule
